// File: rtl/controle_lcd.sv
// Sequencer for a 16x2 HD44780-style character LCD: power-up/init, then
// single-character writes and clear requests through a busy/request handshake.
module controle_lcd #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       escreve,
  input  logic       limpa,
  input  logic [4:0] posicao,
  input  logic [7:0] caractere,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int unsigned MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int unsigned MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned T_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(T_MAX + 1);
  localparam int unsigned N_INIT = 5;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  // Which step of the higher-level sequence the current byte belongs to.
  typedef enum logic [1:0] {
    J_INIT,
    J_ADDR,
    J_DATA,
    J_CLEAR
  } job_t;

  state_t          state;
  job_t            job;
  logic [CW-1:0]   cnt;
  logic [2:0]      init_idx;
  logic            long_wait;
  logic [4:0]      pos;
  logic [7:0]      ch;
  logic [4:0]      cursor;
  logic            cursor_valid;
  logic            wait_done;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h38;
      3'd2:    init_byte = 8'h0C;
      3'd3:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // DDRAM set-address command: line 1 at 0x00, line 2 at 0x40.
  function automatic logic [7:0] addr_cmd(input logic [4:0] p);
    addr_cmd = {1'b1, p[4], 2'b00, p[3:0]};
  endfunction

  assign LCD_RW = 1'b0;

  assign wait_done = long_wait ? (cnt == CW'(T_CLEAR - 1)) : (cnt == CW'(T_CMD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_POWERUP;
      job          <= J_INIT;
      cnt          <= '0;
      init_idx     <= '0;
      long_wait    <= 1'b0;
      pos          <= '0;
      ch           <= '0;
      cursor       <= '0;
      cursor_valid <= 1'b0;
      ocupado      <= 1'b1;
      pronto       <= 1'b0;
      LCD_DATA     <= 8'h00;
      LCD_RS       <= 1'b0;
      LCD_EN       <= 1'b0;
    end else begin
      case (state)
        ST_POWERUP: begin
          if (cnt == CW'(T_POWERUP - 1)) begin
            cnt      <= '0;
            job      <= J_INIT;
            init_idx <= '0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_byte(3'd0);
            state    <= ST_SETUP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_SETUP: begin
          LCD_EN <= 1'b1;
          cnt    <= '0;
          state  <= ST_PULSE;
        end

        ST_PULSE: begin
          if (cnt == CW'(T_EN - 1)) begin
            LCD_EN <= 1'b0;
            cnt    <= '0;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_HOLD: begin
          long_wait <= !LCD_RS && (LCD_DATA == 8'h01);
          cnt       <= '0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_done) begin
            cnt <= '0;
            case (job)
              J_INIT: begin
                if (init_idx == 3'(N_INIT - 1)) begin
                  pronto       <= 1'b1;
                  cursor       <= '0;
                  cursor_valid <= 1'b1;
                  ocupado      <= 1'b0;
                  state        <= ST_IDLE;
                end else begin
                  init_idx <= init_idx + 3'd1;
                  LCD_RS   <= 1'b0;
                  LCD_DATA <= init_byte(init_idx + 3'd1);
                  state    <= ST_SETUP;
                end
              end
              J_ADDR: begin
                job      <= J_DATA;
                LCD_RS   <= 1'b1;
                LCD_DATA <= ch;
                state    <= ST_SETUP;
              end
              J_DATA: begin
                // The controller does not wrap line 1 into line 2, so the
                // cursor is unknown after the last column of either line.
                cursor       <= pos + 5'd1;
                cursor_valid <= (pos[3:0] != 4'hF);
                ocupado      <= 1'b0;
                state        <= ST_IDLE;
              end
              default: begin
                cursor       <= '0;
                cursor_valid <= 1'b1;
                ocupado      <= 1'b0;
                state        <= ST_IDLE;
              end
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_IDLE: begin
          if (limpa) begin
            job      <= J_CLEAR;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h01;
            ocupado  <= 1'b1;
            state    <= ST_SETUP;
          end else if (escreve) begin
            pos     <= posicao;
            ch      <= caractere;
            ocupado <= 1'b1;
            state   <= ST_SETUP;
            if (cursor_valid && (cursor == posicao)) begin
              job      <= J_DATA;
              LCD_RS   <= 1'b1;
              LCD_DATA <= caractere;
            end else begin
              job      <= J_ADDR;
              LCD_RS   <= 1'b0;
              LCD_DATA <= addr_cmd(posicao);
            end
          end
        end

        default: begin
          state <= ST_POWERUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_lcd.sv
// Directed bench for controle_lcd: init sequence timing, cursor-skip logic,
// clear priority and asynchronous reset mid-transfer.
module tb_controle_lcd;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       escreve = 1'b0;
  logic       limpa = 1'b0;
  logic [4:0] posicao = '0;
  logic [7:0] caractere = '0;
  logic       ocupado, pronto, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int failures = 0;
  int cyc;

  controle_lcd #(
    .T_POWERUP(100), .T_EN(4), .T_CMD(10), .T_CLEAR(50)
  ) dut (
    .clock(clock), .reset(reset), .escreve(escreve), .limpa(limpa),
    .posicao(posicao), .caractere(caractere), .ocupado(ocupado), .pronto(pronto),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // One record per EN pulse: {RS,DATA} at rise, width, rise cycle, stability.
  typedef struct {
    logic [8:0] b;
    int         w;
    int         t;
    logic       stable;
  } rec_t;

  rec_t q[$];
  logic       in_pulse = 1'b0;
  logic [8:0] cur_b;
  int         cur_w, cur_t;

  always @(negedge clock) begin
    rec_t r;
    if (reset) begin
      in_pulse = 1'b0;
    end else if (LCD_EN && !in_pulse) begin
      in_pulse = 1'b1;
      cur_b = {LCD_RS, LCD_DATA};
      cur_w = 1;
      cur_t = cyc;
    end else if (LCD_EN) begin
      cur_w++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      r.b = cur_b;
      r.w = cur_w;
      r.t = cur_t;
      r.stable = ({LCD_RS, LCD_DATA} == cur_b) && (LCD_RW == 1'b0);
      q.push_back(r);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input int i, input logic [8:0] exp);
    if (i < q.size()) begin
      chk({name, "_byte"}, int'(q[i].b), int'(exp));
      chk({name, "_width"}, q[i].w, 4);
      chk({name, "_stable"}, int'(q[i].stable), 1);
    end
  endtask

  logic [7:0] init_exp [5];

  task automatic run_init(input bit poke);
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ocupado", int'(ocupado), 1);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_en", int'(LCD_EN), 0);
    chk("rst_rs", int'(LCD_RS), 0);
    chk("rst_rw", int'(LCD_RW), 0);
    chk("rst_data", int'(LCD_DATA), 0);
    if (poke) begin
      escreve = 1'b1;
      limpa = 1'b1;
      posicao = 5'd3;
      caractere = 8'h5A;
    end
    reset = 1'b0;
    q.delete();
    n = 0;
    while (!pronto && n < 400) begin
      @(negedge clock);
      n++;
    end
    escreve = 1'b0;
    limpa = 1'b0;
    if (!pronto) begin
      checks++;
      failures++;
      $display("FAIL init_timeout: pronto never rose within 400 cycles");
    end else begin
      chk("init_ready_cycle", cyc, 220);
      chk("init_ocupado", int'(ocupado), 0);
      chk("init_nbytes", q.size(), 5);
      if (q.size() > 0) chk("init_first_en_cycle", q[0].t, 101);
      for (int i = 0; i < 5; i++) check_byte("init", i, {1'b0, init_exp[i]});
    end
  endtask

  typedef struct {
    logic       lim;
    logic       esc;
    logic [4:0] pos;
    logic [7:0] ch;
    int         nb;
    logic [8:0] b0;
    logic [8:0] b1;
    int         busy;
  } vec_t;

  vec_t vecs [11];

  task automatic apply_vec(input int k, input vec_t v);
    int n;
    string nm;
    nm = $sformatf("v%0d", k);
    n = 0;
    while (ocupado && n < 200) begin
      @(negedge clock);
      n++;
    end
    q.delete();
    limpa = v.lim;
    escreve = v.esc;
    posicao = v.pos;
    caractere = v.ch;
    @(negedge clock);
    limpa = 1'b0;
    escreve = 1'b0;
    n = 0;
    while (ocupado && n < 500) begin
      n++;
      @(negedge clock);
    end
    chk({nm, "_busy"}, n, v.busy);
    chk({nm, "_nbytes"}, q.size(), v.nb);
    check_byte(nm, 0, v.b0);
    if (v.nb > 1) check_byte(nm, 1, v.b1);
  endtask

  initial begin
    int n;
    init_exp = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    //             lim   esc   pos    ch     nb  b0       b1       busy
    vecs[0]  = '{1'b0, 1'b1, 5'd0,  8'h41, 1, 9'h141, 9'h000, 16};
    vecs[1]  = '{1'b0, 1'b1, 5'd17, 8'h42, 2, 9'h0C1, 9'h142, 32};
    vecs[2]  = '{1'b0, 1'b1, 5'd18, 8'h43, 1, 9'h143, 9'h000, 16};
    vecs[3]  = '{1'b0, 1'b1, 5'd15, 8'h44, 2, 9'h08F, 9'h144, 32};
    vecs[4]  = '{1'b0, 1'b1, 5'd16, 8'h45, 2, 9'h0C0, 9'h145, 32};
    vecs[5]  = '{1'b1, 1'b1, 5'd5,  8'h5A, 1, 9'h001, 9'h000, 56};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  8'h46, 1, 9'h146, 9'h000, 16};
    vecs[7]  = '{1'b0, 1'b1, 5'd31, 8'h47, 2, 9'h0CF, 9'h147, 32};
    vecs[8]  = '{1'b0, 1'b1, 5'd0,  8'h48, 2, 9'h080, 9'h148, 32};
    vecs[9]  = '{1'b0, 1'b1, 5'd1,  8'h49, 1, 9'h149, 9'h000, 16};
    vecs[10] = '{1'b1, 1'b0, 5'd9,  8'h00, 1, 9'h001, 9'h000, 56};

    run_init(1'b0);
    for (int k = 0; k < 11; k++) apply_vec(k, vecs[k]);

    // Reset while EN is high during the second init byte.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    n = 0;
    while (!(q.size() >= 1 && LCD_EN) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("midrst_reached_2nd_en", int'(LCD_EN), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_en", int'(LCD_EN), 0);
    chk("midrst_pronto", int'(pronto), 0);
    chk("midrst_data", int'(LCD_DATA), 0);
    chk("midrst_ocupado", int'(ocupado), 1);

    run_init(1'b1);
    apply_vec(99, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_lcd.md
Name: controle_lcd

Overview:
- Sequencer for the board's 16x2 HD44780-style character LCD, replacing the free-running LCD test pattern with a processor-addressable display.
- After reset it runs the LCD power-up and init sequence on its own.
- It then accepts single-character write requests (position 0-31, plus a clear command) from the I/O datapath (saidaDados side) through a busy/request handshake.
- It generates all RS/RW/EN/DATA timing and tracks the LCD cursor so it can skip redundant address commands.

Parameters:
T_POWERUP, 750000, cycles to wait after reset before the first command (15 ms at 50 MHz)
T_EN, 16, cycles LCD_EN is held high per byte
T_CMD, 2000, post-byte wait cycles for ordinary commands and data (40 us)
T_CLEAR, 82000, post-byte wait cycles after the 0x01 clear command (1.64 ms)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-high reset
escreve  input  1  character write request, sampled on the rising edge
limpa  input  1  clear-display request, sampled on the rising edge
posicao  input  5  character position; 0-15 is line 1, 16-31 is line 2
caractere  input  8  ASCII code to write
ocupado  output  1  controller busy; requests are ignored while high
pronto  output  1  init sequence complete (sticky until reset)
LCD_DATA  output  8  LCD data bus (write-only; controller always drives it)
LCD_RS  output  1  0 = command, 1 = data
LCD_RW  output  1  constant 0
LCD_EN  output  1  LCD enable strobe

Behaviour:
Reset values (asynchronous, active-high):
- ocupado=1, pronto=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
- Cursor register=0, cursor-valid flag=0.
- FSM state=POWERUP, counters cleared.

Reset mid-operation:
- Aborts everything immediately: EN drops asynchronously and init restarts from POWERUP.

Byte transfer sub-sequence (shared by every command and data byte):
- SETUP: 1 cycle, RS/DATA driven, EN=0.
- PULSE: T_EN cycles, EN=1.
- HOLD: 1 cycle, EN=0, RS/DATA held.
- WAIT: T_CMD cycles, or T_CLEAR if the byte was the 0x01 command.
- Total per byte: T_EN+T_CMD+2 cycles, or T_EN+T_CLEAR+2 for 0x01.
- RS/DATA stay stable from SETUP through the end of WAIT.

Main FSM:
- POWERUP: count T_POWERUP cycles, then go to INIT.
- INIT: send commands 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. Then set pronto=1, cursor=0, valid=1, and go to IDLE.
- IDLE: ocupado=0. On the rising edge where limpa=1, go to CLEAR; limpa has priority and a simultaneous escreve is dropped. Otherwise, if escreve=1, capture posicao/caractere and go to ADDR.
- From the acceptance edge onward, ocupado=1. The request inputs are don't-care until ocupado falls.
- ADDR: if valid=1 and cursor==posicao, skip to DATA. Otherwise send command 0x80|posicao[3:0] when posicao<16, or 0xC0|posicao[3:0] when posicao≥16, with RS=0.
- DATA: send the captured caractere with RS=1. Then cursor=posicao+1. Set valid=0 if posicao is 15 or 31 (the HD44780 does not wrap line 1 to line 2), else valid=1. Return to IDLE.
- CLEAR: send 0x01 with the T_CLEAR wait. Then cursor=0, valid=1, return to IDLE.

ocupado timing:
- Falls in the same cycle the FSM re-enters IDLE.
- A new request may be accepted on the first IDLE edge.
- Requests arriving during POWERUP or INIT are ignored; no queueing.

Arithmetic:
- Cursor is 5 bits; posicao+1 is taken modulo 32.
- Wait counters must be wide enough for T_POWERUP (20 bits at defaults).

Test Plan:
(Bench uses T_POWERUP=100, T_EN=4, T_CMD=10, T_CLEAR=50.)
- Reset release -> no EN activity for 100 cycles. Then 5 EN pulses of 4 cycles each carrying 0x38, 0x38, 0x0C, 0x01, 0x06, all RS=0. pronto and !ocupado exactly 220 cycles after reset release (100+4×16+56).
- After init, escreve with posicao=0 and caractere=0x41 -> no address byte (cursor valid at 0). One RS=1 transfer of 0x41; ocupado high for 16 cycles.
- Then escreve with posicao=17 and caractere=0x42 -> command 0xC1 (RS=0) followed by 0x42 (RS=1); ocupado high for 32 cycles. A following write to posicao=18 emits data only.
- Write to posicao=15, then to posicao=16 -> the second write emits 0xC0 before its data, because the cursor is invalidated after position 15.
- escreve and limpa both high on the same IDLE edge -> only 0x01 is sent, ocupado high for 56 cycles. A subsequent write to posicao=0 emits no address byte.
- Assert reset while LCD_EN=1 during the second init byte -> LCD_EN, pronto and LCD_DATA go to 0 immediately (asynchronously). After release, the full 220-cycle init sequence replays from the start.
